// File: rtl/q2a03_pkg.sv
// q2a03_pkg: shared types, P-bit positions, vectors and interrupt FSM states for the Q2A03 core
package q2a03_pkg;
  typedef logic [7:0] reg8_type;
  typedef logic [15:0] reg16_type;
  localparam int C_bit = 0;
  localparam int Z_bit = 1;
  localparam int I_bit = 2;
  localparam int D_bit = 3;
  localparam int B_bit = 4;
  localparam int U_bit = 5;
  localparam int V_bit = 6;
  localparam int N_bit = 7;
  localparam reg16_type NMI_VECTOR = 16'hFFFA;
  localparam reg16_type RES_VECTOR = 16'hFFFC;
  localparam reg16_type IRQ_VECTOR = 16'hFFFE;
  localparam logic [2:0] RES_CHAN = 3'd7;
  typedef enum logic {ST_IDLE, ST_SERVICE} int_state_type;
endpackage

// File: rtl/q2a03_int_sync.sv
// q2a03_int_sync: W-bit 2-flop synchroniser, flops reset to 1 (idle level of active-low lines)
module q2a03_int_sync #(
  parameter int W = 1
) (
  input  logic         G_clock,
  input  logic         G_reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge G_clock or negedge G_reset)
    if (!G_reset) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/q2a03_int_ctrl.sv
// q2a03_int_ctrl: N-channel edge/level, maskable/non-maskable interrupt arbiter with reset priority.
// Define Q2A03_INT_SYNC_EN to pass G_irq_n through a 2-flop synchroniser first.
module q2a03_int_ctrl
  import q2a03_pkg::*;
#(
  parameter int        CHANNELS  = 4,
  parameter logic [7:0] EDGE_MASK = 8'b0001,
  parameter logic [7:0] MASKABLE  = 8'b1110,
  parameter reg16_type VEC_BASE  = 16'hFFE0,
  parameter reg16_type RES_VEC   = RES_VECTOR
) (
  input  logic                G_clock,
  input  logic                G_reset,
  input  logic                G_ready,
  input  logic                G_phase_fall,
  input  logic                G_sync,
  input  logic                G_i_flag,
  input  logic [CHANNELS-1:0] G_irq_n,
  input  logic [CHANNELS-1:0] G_en,
  output logic                G_take,
  output logic                G_ack,
  output reg16_type           G_vec_addr,
  output logic [2:0]          G_chan,
  output logic                G_busy
);
  localparam logic [CHANNELS-1:0] EM = EDGE_MASK[CHANNELS-1:0];
  localparam logic [CHANNELS-1:0] MK = MASKABLE[CHANNELS-1:0];
  int_state_type state;
  logic [CHANNELS-1:0] irq, last, pend, fall, elig, clr;
  logic [2:0] win;
  logic res_pend, strobe, accept;
`ifdef Q2A03_INT_SYNC_EN
  q2a03_int_sync #(.W(CHANNELS)) u_sync (
    .G_clock(G_clock),
    .G_reset(G_reset),
    .d      (G_irq_n),
    .q      (irq)
  );
`else
  assign irq = G_irq_n;
`endif
  assign fall = last & ~irq & G_en & EM;
  assign elig = ((EM & pend) | (~EM & ~irq & G_en)) & ~(MK & {CHANNELS{G_i_flag}});
  // Descending scan so the lowest eligible index is the one left standing
  always_comb begin
    win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (elig[i]) win = 3'(i);
  end
  assign G_take = (state == ST_IDLE) & (res_pend | (|elig));
  assign strobe = G_phase_fall & G_sync;
  assign accept = strobe & G_take;
  assign clr    = (accept & ~res_pend) ? (CHANNELS'(1) << win) & EM : '0;
  assign G_busy = (state == ST_SERVICE);
  // A fresh edge in the accept clock re-sets the bit it clears; disable overrides both
  always_ff @(posedge G_clock or negedge G_reset)
    if (!G_reset) begin
      state      <= ST_IDLE;
      pend       <= '0;
      last       <= '1;
      res_pend   <= 1'b1;
      G_ack      <= 1'b0;
      G_chan     <= RES_CHAN;
      G_vec_addr <= RES_VEC;
    end else if (G_ready) begin
      last  <= irq;
      pend  <= (pend & ~clr | fall) & G_en;
      G_ack <= accept;
      if (accept) begin
        state      <= ST_SERVICE;
        res_pend   <= 1'b0;
        G_chan     <= res_pend ? RES_CHAN : win;
        G_vec_addr <= res_pend ? RES_VEC : VEC_BASE + {12'd0, win, 1'b0};
      end else if (strobe) begin
        state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_q2a03_int_ctrl.sv
// tb_q2a03_int_ctrl: directed + randomized checks of q2a03_int_ctrl against a behavioural model
module tb_q2a03_int_ctrl;
  localparam logic [7:0] EM = 8'b0001;
  localparam logic [7:0] MK = 8'b1110;
`ifdef Q2A03_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst_n = 0, ready = 1, phase = 0, sync = 0, iflag = 0;
  logic [3:0] irq_n = '1, en = '1;
  logic take, ack, busy;
  logic [15:0] vec;
  logic [2:0] chan;
  int checks = 0, errors = 0;
  bit mp[4], ml[4], mres, mserv, mack;
  int mchan;
  logic [15:0] mvec;
  logic [3:0] p1, p2;

  q2a03_int_ctrl dut (
    .G_clock(clk), .G_reset(rst_n), .G_ready(ready), .G_phase_fall(phase),
    .G_sync(sync), .G_i_flag(iflag), .G_irq_n(irq_n), .G_en(en),
    .G_take(take), .G_ack(ack), .G_vec_addr(vec), .G_chan(chan), .G_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin mp[i] = 0; ml[i] = 1; end
    mres = 1; mserv = 0; mack = 0; mchan = 7; mvec = 16'hFFFC; p1 = '1; p2 = '1;
  endtask

  function automatic logic [3:0] eff();
`ifdef Q2A03_INT_SYNC_EN
    return p2;
`else
    return irq_n;
`endif
  endfunction

  // Eligibility from the rules: edge channels use the latched request, level ones the live line
  task automatic melig(output bit any, output int w);
    logic [3:0] e;
    e = eff();
    any = 0; w = 0;
    for (int i = 3; i >= 0; i--) begin
      bit req;
      req = EM[i] ? mp[i] : (!e[i] && en[i]);
      if (req && !(MK[i] && iflag)) begin any = 1; w = i; end
    end
  endtask

  task automatic cyc();
    bit any, t, fl;
    int w, clrw;
    logic [3:0] e;
    #3;
    melig(any, w);
    t = !mserv && (mres || any);
    chk("take", take, t);
    @(posedge clk);
    e = eff();
    if (ready) begin
      mack = 0; clrw = -1;
      if (t && phase && sync) begin
        mack = 1; mserv = 1;
        if (mres) begin mchan = 7; mvec = 16'hFFFC; mres = 0; end
        else begin mchan = w; mvec = 16'hFFE0 + 16'(2 * w); clrw = w; end
      end else if (mserv && phase && sync) mserv = 0;
      for (int i = 0; i < 4; i++) begin
        fl = EM[i] && ml[i] && !e[i];
        mp[i] = en[i] && ((mp[i] && i != clrw) || fl);
        ml[i] = e[i];
      end
    end
    p2 = p1; p1 = irq_n;
    #1;
    chk("ack", ack, mack);
    chk("chan", chan, mchan[2:0]);
    chk("vec", vec, mvec);
    chk("busy", busy, mserv);
    #1;
  endtask

  task automatic bnd();
    phase = 1; sync = 1; cyc();
    phase = 0; sync = 0; cyc();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    mreset();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_chan", chan, 7);
    chk("rst_vec", vec, 16'hFFFC);
    chk("rst_take", take, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    int lat;
    mreset();
    #17 rst_n = 1;
    cyc(); cyc();
    bnd();
    chk("res_chan", chan, 7);
    chk("res_vec", vec, 16'hFFFC);
    bnd();
    iflag = 1; irq_n[0] = 0; cyc(); irq_n[0] = 1; cyc();
    bnd();
    chk("nmi_chan", chan, 0);
    chk("nmi_vec", vec, 16'hFFE0);
    irq_n[0] = 0; cyc(); irq_n[0] = 1; cyc();
    bnd();
    chk("nmi_held_busy", busy, 0);
    bnd();
    chk("nmi2_chan", chan, 0);
    bnd();
    irq_n[2] = 0; cyc();
    chk("masked_take", take, 0);
    iflag = 0;
    bnd();
    chk("irq2_vec", vec, 16'hFFE4);
    bnd(); bnd();
    chk("irq2_again", chan, 2);
    bnd();
    irq_n[2] = 1;
    irq_n[1] = 0; irq_n[3] = 0;
    bnd();
    chk("prio_vec", vec, 16'hFFE2);
    bnd();
    irq_n[1] = 1;
    bnd();
    chk("ch3_vec", vec, 16'hFFE6);
    bnd();
    irq_n[3] = 1; cyc();
    en[0] = 0; irq_n[0] = 0; cyc(); irq_n[0] = 1; cyc(); en[0] = 1; cyc();
    chk("dis_edge_take", take, 0);
    irq_n[0] = 0; cyc();
    chk("edge_take", take, 1);
    irq_n[0] = 1; en[0] = 0; cyc();
    chk("dis_clear_take", take, 0);
    en[0] = 1; cyc();
    chk("dis_cleared", take, 0);
    irq_n[2] = 0; phase = 1; sync = 1; cyc(); phase = 0; sync = 0;
    chk("svc_busy", busy, 1);
    do_reset();
    irq_n[2] = 1;
    cyc();
    chk("post_rst_vec", vec, 16'hFFFC);
    bnd(); bnd();
    irq_n[1] = 0; ready = 0; phase = 1; sync = 1; cyc();
    chk("stall_ack", ack, 0);
    ready = 1; phase = 0; sync = 0;
    bnd();
    chk("stall_chan", chan, 1);
    irq_n[1] = 1; bnd();
    cyc(); cyc(); cyc();
    irq_n[0] = 0; lat = 0;
    while (lat < 10) begin
      cyc(); lat++;
      if (take) break;
    end
    chk("edge_latency", 16'(lat), 16'(LAT));
    irq_n[0] = 1; bnd(); bnd();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) irq_n[i] = ~irq_n[i];
        if ($urandom_range(15) == 0) en[i] = ~en[i];
      end
      if ($urandom_range(3) == 0) iflag = $urandom_range(1);
      ready = ($urandom_range(7) != 0);
      phase = ($urandom_range(2) == 0);
      sync = $urandom_range(1);
      if ($urandom_range(199) == 0) do_reset();
      else cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
